// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: line geometry defaults and the L2 arbiter state set.
package lc3b_types;

    localparam int ADR_W_DEF = 12;   // line address, byte address [15:4]
    localparam int DAT_W_DEF = 128;  // one cache line of eight 16-bit words
    localparam int SEL_W_DEF = 16;
    localparam int CNT_W     = 16;

    typedef logic [DAT_W_DEF-1:0] lc3b_8words;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_e;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one Wishbone L2 slave between the I-cache and D-cache.
// Every transaction returns to IDLE before the next grant, so a grant costs one idle cycle.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = $bits(lc3b_8words),
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [ADR_W-1:0] i_adr,
    input  logic [DAT_W-1:0] i_dat_m,
    input  logic [SEL_W-1:0] i_sel,
    output logic [DAT_W-1:0] i_dat_s,
    output logic             i_ack,
    output logic             i_rty,

    input  logic             d_cyc,
    input  logic             d_stb,
    input  logic             d_we,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [DAT_W-1:0] d_dat_m,
    input  logic [SEL_W-1:0] d_sel,
    output logic [DAT_W-1:0] d_dat_s,
    output logic             d_ack,
    output logic             d_rty,

    output logic             l2_cyc,
    output logic             l2_stb,
    output logic             l2_we,
    output logic [ADR_W-1:0] l2_adr,
    output logic [DAT_W-1:0] l2_dat_m,
    output logic [SEL_W-1:0] l2_sel,
    input  logic [DAT_W-1:0] l2_dat_s,
    input  logic             l2_ack,
    input  logic             l2_rty,

    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    arb_state_e state, state_next;
    master_e    last_served;
    logic       req_i, req_d;
    logic       unused_l2_rty;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

    // The L2 retry response carries no meaning here; the grant simply waits for l2_ack.
    assign unused_l2_rty = l2_rty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (req_i && req_d) begin
                    state_next = (last_served == MST_D) ? ARB_GNT_I : ARB_GNT_D;
                end else if (req_i) begin
                    state_next = ARB_GNT_I;
                end else if (req_d) begin
                    state_next = ARB_GNT_D;
                end
            end
            ARB_GNT_I: if (l2_ack || !i_cyc) state_next = ARB_IDLE;
            ARB_GNT_D: if (l2_ack || !d_cyc) state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // State is forced to IDLE asynchronously, so reset alone silences the bus and the acks.
    always_comb begin
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_dat_m = '0;
        l2_sel   = '0;
        i_dat_s  = '0;
        d_dat_s  = '0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        unique case (state)
            ARB_GNT_I: begin
                l2_cyc   = i_cyc;
                l2_stb   = i_stb;
                l2_we    = i_we;
                l2_adr   = i_adr;
                l2_dat_m = i_dat_m;
                l2_sel   = i_sel;
                i_dat_s  = l2_dat_s;
                i_ack    = l2_ack;
            end
            ARB_GNT_D: begin
                l2_cyc   = d_cyc;
                l2_stb   = d_stb;
                l2_we    = d_we;
                l2_adr   = d_adr;
                l2_dat_m = d_dat_m;
                l2_sel   = d_sel;
                d_dat_s  = l2_dat_s;
                d_ack    = l2_ack;
            end
            default: ;
        endcase
        i_rty = req_i & ~i_ack;
        d_rty = req_d & ~d_ack;
    end

    // A completion wins over a same-cycle abort: only l2_ack decides whether it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= MST_D;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            wait_cnt    <= '0;
        end else begin
            if (state == ARB_GNT_I && l2_ack) begin
                last_served <= MST_I;
                i_grant_cnt <= i_grant_cnt + 16'd1;
            end
            if (state == ARB_GNT_D && l2_ack) begin
                last_served <= MST_D;
                d_grant_cnt <= d_grant_cnt + 16'd1;
            end
            if ((req_i && state != ARB_GNT_I) || (req_d && state != ARB_GNT_D)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised bench for cache_arbiter: a transaction-level owner/round-robin model predicts
// every output each cycle, with directed scenarios for latency, fairness, abort, reset and wrap.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;

    bit           cyc [2];
    bit           stb [2];
    bit           we  [2];
    logic [11:0]  adr [2];
    logic [127:0] datm[2];
    logic [15:0]  sel [2];

    logic [127:0] l2_dat_s_r;
    logic         l2_ack_r, l2_rty_r;

    logic [127:0] i_dat_s, d_dat_s, l2_dat_m;
    logic         i_ack, i_rty, d_ack, d_rty;
    logic         l2_cyc, l2_stb, l2_we;
    logic [11:0]  l2_adr;
    logic [15:0]  l2_sel;
    logic [15:0]  i_grant_cnt, d_grant_cnt, wait_cnt;

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(cyc[0]), .i_stb(stb[0]), .i_we(we[0]), .i_adr(adr[0]),
        .i_dat_m(datm[0]), .i_sel(sel[0]), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(cyc[1]), .d_stb(stb[1]), .d_we(we[1]), .d_adr(adr[1]),
        .d_dat_m(datm[1]), .d_sel(sel[1]), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
        .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr),
        .l2_dat_m(l2_dat_m), .l2_sel(l2_sel), .l2_dat_s(l2_dat_s_r),
        .l2_ack(l2_ack_r), .l2_rty(l2_rty_r),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: who owns the L2 (-1 none, 0 I, 1 D) and who was served last.
    int          owner, last, gnt_age, edge_no;
    logic [15:0] m_gcnt[2];
    logic [15:0] m_wait;
    int          txn_left[2];
    bit          drop_pending[2];
    int          done_edge[2];
    int          grant_order[$];
    int          grant_edge[$];
    int          ack_seen[2];
    int          ack_mode, ack_lat;   // 0 fixed latency, 1 random, 2 always, 3 never
    int          total = 0, bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit req(input int m);
        return cyc[m] && stb[m];
    endfunction

    task automatic model_reset();
        owner = -1; last = 1; gnt_age = 0; edge_no = 0; m_wait = '0;
        for (int m = 0; m < 2; m++) begin
            m_gcnt[m] = '0; txn_left[m] = 0; drop_pending[m] = 0;
            done_edge[m] = 0; ack_seen[m] = 0;
            cyc[m] = 0; stb[m] = 0; we[m] = 0; adr[m] = '0; datm[m] = '0; sel[m] = '0;
        end
        grant_order.delete();
        grant_edge.delete();
    endtask

    task automatic new_req(input int m, input int n);
        cyc[m] = 1; stb[m] = 1; we[m] = 1'($urandom); adr[m] = 12'($urandom);
        datm[m] = {$urandom, $urandom, $urandom, $urandom}; sel[m] = 16'($urandom);
        txn_left[m] = n;
    endtask

    task automatic check_outputs();
        logic         e_cyc, e_stb, e_we;
        logic [11:0]  e_adr;
        logic [127:0] e_dat;
        logic [15:0]  e_sel;
        bit           e_ack[2];
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        if (owner >= 0) begin
            e_cyc = cyc[owner]; e_stb = stb[owner]; e_we = we[owner];
            e_adr = adr[owner]; e_dat = datm[owner]; e_sel = sel[owner];
        end
        for (int m = 0; m < 2; m++) e_ack[m] = l2_ack_r && (owner == m);
        check("l2_cyc", l2_cyc, e_cyc);
        check("l2_stb", l2_stb, e_stb);
        check("l2_we", l2_we, e_we);
        check("l2_adr", l2_adr, e_adr);
        check("l2_dat_m", l2_dat_m, e_dat);
        check("l2_sel", l2_sel, e_sel);
        check("i_ack", i_ack, e_ack[0]);
        check("d_ack", d_ack, e_ack[1]);
        check("i_rty", i_rty, req(0) && !e_ack[0]);
        check("d_rty", d_rty, req(1) && !e_ack[1]);
        check("i_dat_s", i_dat_s, (owner == 0) ? l2_dat_s_r : 128'd0);
        check("d_dat_s", d_dat_s, (owner == 1) ? l2_dat_s_r : 128'd0);
        check("i_grant_cnt", i_grant_cnt, m_gcnt[0]);
        check("d_grant_cnt", d_grant_cnt, m_gcnt[1]);
        check("wait_cnt", wait_cnt, m_wait);
    endtask

    // Advance the model across one rising edge using the inputs held during that cycle.
    task automatic model_update();
        bit waiting = 0;
        int nxt;
        edge_no++;
        for (int m = 0; m < 2; m++) if (req(m) && owner != m) waiting = 1;
        if (waiting) m_wait = m_wait + 16'd1;
        if (owner < 0) begin
            if (req(0) && req(1)) nxt = (last == 1) ? 0 : 1;
            else if (req(0))      nxt = 0;
            else if (req(1))      nxt = 1;
            else                  nxt = -1;
            if (nxt >= 0) begin
                owner = nxt; gnt_age = 0;
                grant_order.push_back(nxt);
                grant_edge.push_back(edge_no);
            end
        end else if (l2_ack_r) begin
            m_gcnt[owner] = m_gcnt[owner] + 16'd1;
            last = owner;
            done_edge[owner] = edge_no;
            if (txn_left[owner] > 0) begin
                txn_left[owner]--;
                if (txn_left[owner] == 0) drop_pending[owner] = 1;
            end
            owner = -1;
        end else if (!cyc[owner]) begin
            owner = -1;
        end else begin
            gnt_age++;
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step(input bit chk);
        case (ack_mode)
            0:       l2_ack_r = (owner >= 0) && (gnt_age >= ack_lat);
            1:       l2_ack_r = ($urandom_range(0, 3) == 0);
            2:       l2_ack_r = 1'b1;
            default: l2_ack_r = 1'b0;
        endcase
        l2_rty_r   = 1'($urandom);
        l2_dat_s_r = {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (chk) check_outputs();
        if (i_ack) ack_seen[0]++;
        if (d_ack) ack_seen[1]++;
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int m = 0; m < 2; m++) if (drop_pending[m]) begin
            cyc[m] = 0; stb[m] = 0; drop_pending[m] = 0;
        end
    endtask

    task automatic run_drain(input int budget);
        int k = 0;
        while ((txn_left[0] > 0 || txn_left[1] > 0) && k < budget) begin
            step(1);
            k++;
        end
        check("drain", txn_left[0] + txn_left[1], 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        l2_ack_r = 1'b1;
        #2;
        check("rst_l2_cyc", l2_cyc, 1'b0);
        check("rst_i_ack", i_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_cnt", {i_grant_cnt, d_grant_cnt, wait_cnt}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        l2_ack_r = 0; l2_rty_r = 0; l2_dat_s_r = '0;
        ack_mode = 0; ack_lat = 0;
        do_reset();

        // I-cache read of line 0x123, L2 acks three cycles into the grant.
        ack_mode = 0; ack_lat = 3;
        new_req(0, 1); we[0] = 0; adr[0] = 12'h123;
        step(1);
        check("s1_adr", l2_adr, 12'h123);
        check("s1_cyc", l2_cyc, 1'b1);
        run_drain(20);
        check("s1_acks", ack_seen[0], 1);
        check("s1_cnt", i_grant_cnt, 16'd1);

        // Tie after reset: I first, D one idle cycle after I completes.
        do_reset();
        ack_mode = 0; ack_lat = 2;
        new_req(0, 1); new_req(1, 1);
        run_drain(30);
        check("s2_n", grant_order.size(), 2);
        check("s2_first", grant_order[0], 0);
        check("s2_gap", grant_edge[1] - done_edge[0], 1);

        // Continuous contention: ten grants alternating I,D.
        do_reset();
        ack_mode = 0; ack_lat = 1;
        new_req(0, 5); new_req(1, 5);
        run_drain(200);
        check("s3_n", grant_order.size(), 10);
        foreach (grant_order[k]) check("s3_alt", grant_order[k], k % 2);
        check("s3_icnt", i_grant_cnt, 16'd5);
        check("s3_dcnt", d_grant_cnt, 16'd5);

        // D write with 0xA5 data.
        ack_seen[0] = 0;
        new_req(1, 1); we[1] = 1; datm[1] = {16{8'hA5}}; sel[1] = 16'hFFFF;
        ack_mode = 0; ack_lat = 2;
        step(1);
        check("s4_we", l2_we, 1'b1);
        check("s4_dat", l2_dat_m, {16{8'hA5}});
        run_drain(20);
        check("s4_no_iack", ack_seen[0], 0);

        // D aborts mid-grant; a later ack must not reach it.
        do_reset();
        ack_mode = 3;
        new_req(1, 1);
        step(1); step(1);
        cyc[1] = 0; txn_left[1] = 0;
        step(1);
        check("s5_idle", l2_cyc, 1'b0);
        ack_mode = 2;
        step(1); step(1);
        check("s5_cnt", d_grant_cnt, 16'd0);
        check("s5_acks", ack_seen[1], 0);

        // Abort coinciding with ack counts as completion.
        ack_mode = 3;
        new_req(1, 1);
        step(1); step(1);
        cyc[1] = 0; txn_left[1] = 0; ack_mode = 2;
        step(1);
        check("s6_cnt", d_grant_cnt, 16'd1);

        // Reset during GNT_I after I was served last; I must still win the next tie.
        do_reset();
        ack_mode = 0; ack_lat = 0;
        new_req(0, 1);
        run_drain(10);
        ack_mode = 3;
        new_req(0, 1);
        step(1); step(1);
        check("s7_pre", l2_cyc, 1'b1);
        l2_ack_r = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("s7_cyc", l2_cyc, 1'b0);
        check("s7_stb", l2_stb, 1'b0);
        check("s7_ack", i_ack, 1'b0);
        check("s7_rty", i_rty, 1'b1);
        check("s7_cnt", i_grant_cnt, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ack_mode = 0; ack_lat = 1;
        new_req(0, 1); new_req(1, 1);
        run_drain(30);
        check("s7_first", grant_order[0], 0);

        // Randomised traffic with aborts and stb toggling.
        do_reset();
        ack_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!cyc[m]) begin
                    if ($urandom_range(0, 2) == 0) new_req(m, $urandom_range(1, 3));
                end else if (owner == m) begin
                    if ($urandom_range(0, 19) == 0) begin cyc[m] = 0; txn_left[m] = 0; end
                end else if ($urandom_range(0, 9) == 0) begin
                    stb[m] = ~stb[m];
                end
            end
            step(1);
        end

        // wait_cnt wraps: I holds the bus forever while D keeps asking.
        do_reset();
        ack_mode = 3;
        new_req(0, 1); new_req(1, 1);
        for (int n = 0; n < 65541; n++) step(0);
        check("wrap_wait", wait_cnt, 16'd5);
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
